// File: rtl/mimosa_pkg.sv
// mimosa_pkg: mood state encoding, default gains and reset levels shared by the affect blocks
package mimosa_pkg;
  typedef enum logic [1:0] {AWAKE = 2'b00, SLEEP = 2'b01, EXHAUSTED = 2'b10} mood_t;
  localparam int ENERGY_DECAY_DEF = 1;
  localparam int SLEEP_GAIN_DEF = 4;
  localparam int FEED_GAIN_DEF = 32;
  localparam int TOUCH_GAIN_DEF = 16;
  localparam int PLAY_GAIN_DEF = 24;
  localparam int DECAY_DEF = 1;
  localparam logic [7:0] ENERGY_RST = 8'd128;
  localparam logic [7:0] STRESS_RST = 8'd0;
  localparam logic [7:0] PLEASURE_RST = 8'd128;
  function automatic logic signed [9:0] d10(int v);
    return 10'(v);
  endfunction
endpackage

// File: rtl/sat_level.sv
// sat_level: applies a signed delta to an 8-bit level, clamping to 0..255
module sat_level (
  input  logic [7:0]        lvl,
  input  logic signed [9:0] delta,
  output logic [7:0]        nxt
);
  logic signed [10:0] sum;
  assign sum = $signed({3'b000, lvl}) + 11'(delta);
  assign nxt = sum[10] ? 8'd0 : |sum[9:8] ? 8'd255 : sum[7:0];
endmodule

// File: rtl/affect_integrator.sv
// affect_integrator: integrates tick/feed/touch/play into energy, stress and pleasure levels and a mood FSM
module affect_integrator
  import mimosa_pkg::*;
#(
  parameter int ENERGY_DECAY = ENERGY_DECAY_DEF,
  parameter int SLEEP_GAIN   = SLEEP_GAIN_DEF,
  parameter int FEED_GAIN    = FEED_GAIN_DEF,
  parameter int TOUCH_GAIN   = TOUCH_GAIN_DEF,
  parameter int PLAY_GAIN    = PLAY_GAIN_DEF,
  parameter int DECAY        = DECAY_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       feed,
  input  logic       touch,
  input  logic       play,
  input  logic       night,
  output logic [1:0] energy,
  output logic [1:0] stress,
  output logic [1:0] pleasure,
  output logic [1:0] mood_state,
  output logic       mood_update
);
  localparam logic signed [9:0] ED  = d10(ENERGY_DECAY);
  localparam logic signed [9:0] SG  = d10(SLEEP_GAIN);
  localparam logic signed [9:0] FG  = d10(FEED_GAIN);
  localparam logic signed [9:0] TG  = d10(TOUCH_GAIN);
  localparam logic signed [9:0] PG  = d10(PLAY_GAIN);
  localparam logic signed [9:0] DC  = d10(DECAY);
  localparam logic signed [9:0] DC2 = d10(2 * DECAY);
  mood_t             state, state_nxt;
  logic [7:0]        e_lvl, s_lvl, p_lvl, e_nxt, s_nxt, p_nxt;
  logic signed [9:0] de, ds, dp;
  logic              chg;
  // sum every contribution active this cycle; exhaustion mutes play, high stress doubles pleasure decay
  always_comb begin
    de = (feed ? FG : 10'sd0) + (!tick ? 10'sd0 : state == AWAKE ? -ED : state == SLEEP ? SG : 10'sd0);
    ds = (touch ? TG : 10'sd0) + (!tick ? 10'sd0 : state == AWAKE ? -DC : state == SLEEP ? -DC2 : 10'sd1);
    dp = (play && state != EXHAUSTED ? PG : 10'sd0) - (!tick ? 10'sd0 : s_lvl >= 8'd192 ? DC2 : DC);
  end
  sat_level u_energy   (.lvl(e_lvl), .delta(de), .nxt(e_nxt));
  sat_level u_stress   (.lvl(s_lvl), .delta(ds), .nxt(s_nxt));
  sat_level u_pleasure (.lvl(p_lvl), .delta(dp), .nxt(p_nxt));
  // mood transitions look at the post-update energy so state and levels move on the same edge
  always_comb begin
    state_nxt = state == AWAKE ? (e_nxt == 8'd0 ? EXHAUSTED : night ? SLEEP : AWAKE)
              : state == SLEEP ? ((touch || !night || e_nxt == 8'd255) ? AWAKE : SLEEP)
              : (feed ? AWAKE : night ? SLEEP : EXHAUSTED);
    chg = {e_nxt[7:6], s_nxt[7:6], p_nxt[7:6], state_nxt} != {e_lvl[7:6], s_lvl[7:6], p_lvl[7:6], state};
  end
  // level, state and change-flag registers; reset forces the resting mood immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_lvl       <= ENERGY_RST;
      s_lvl       <= STRESS_RST;
      p_lvl       <= PLEASURE_RST;
      state       <= AWAKE;
      mood_update <= 1'b0;
    end else begin
      e_lvl       <= e_nxt;
      s_lvl       <= s_nxt;
      p_lvl       <= p_nxt;
      state       <= state_nxt;
      mood_update <= chg;
    end
  end
  assign energy     = e_lvl[7:6];
  assign stress     = s_lvl[7:6];
  assign pleasure   = p_lvl[7:6];
  assign mood_state = state;
endmodule

// File: tb/tb_affect_integrator.sv
// tb_affect_integrator: directed scenarios with a cycle-stamped scoreboard for affect_integrator
module tb_affect_integrator;
  logic clk = 1'b0, reset = 1'b1, tick = 1'b0, feed = 1'b0, touch = 1'b0, play = 1'b0, night = 1'b0;
  logic [1:0] energy, stress, pleasure, mood_state;
  logic mood_update;
  int checks = 0, failures = 0, cyc = 0, mu_cnt = 0;
  typedef struct {int c; logic [8:0] v; string n;} exp_t;
  exp_t q[$];

  affect_integrator dut (
    .clk(clk), .reset(reset), .tick(tick), .feed(feed), .touch(touch), .play(play), .night(night),
    .energy(energy), .stress(stress), .pleasure(pleasure), .mood_state(mood_state), .mood_update(mood_update)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [8:0] outs();
    return {energy, stress, pleasure, mood_state, mood_update};
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got %h expected %h", n, act, want);
    end
  endtask

  // drive one cycle of inputs at the falling edge
  task automatic step(input logic t, input logic f, input logic to, input logic p, input logic n);
    @(negedge clk);
    tick = t; feed = f; touch = to; play = p; night = n;
  endtask

  // expected outputs after the coming rising edge: {energy, stress, pleasure, mood_state, mood_update}
  task automatic expv(input string n, input int e, input int s, input int p, input int st, input int mu);
    exp_t x;
    x.c = cyc + 1;
    x.v = {e[1:0], s[1:0], p[1:0], st[1:0], mu[0]};
    x.n = n;
    q.push_back(x);
  endtask

  task automatic do_reset(input string n);
    @(negedge clk);
    tick = 0; feed = 0; touch = 0; play = 0; night = 0;
    reset = 1;
    #1 chk(n, 32'(outs()), 32'({2'd2, 2'd0, 2'd2, 2'd0, 1'b0}));
    @(negedge clk);
    reset = 0;
  endtask

  // monitor: after each rising edge, compare every scoreboard entry due this cycle
  initial forever begin
    @(posedge clk);
    #1;
    if (mood_update) mu_cnt++;
    while (q.size() > 0 && q[0].c <= cyc) begin
      exp_t x;
      x = q.pop_front();
      chk(x.n, 32'(outs()), 32'(x.v));
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_state", 32'(outs()), 32'({2'd2, 2'd0, 2'd2, 2'd0, 1'b0}));
    reset = 0;
    // 64 quiet ticks: energy and pleasure drift 128 -> 64
    mu_cnt = 0;
    step(1, 0, 0, 0, 0); expv("idle_tick1", 1, 0, 1, 0, 1);
    step(1, 0, 0, 0, 0); expv("idle_tick2", 1, 0, 1, 0, 0);
    repeat (61) step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0); expv("idle_tick64", 1, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("idle_mu_pulses", 32'(mu_cnt), 32'd1);
    // stress build-up and doubled pleasure decay
    do_reset("reset_async_1");
    for (int i = 1; i <= 12; i++) begin
      step(0, 0, 1, 0, 0);
      if (i == 4) expv("touch4", 2, 1, 2, 0, 1);
      if (i == 8) expv("touch8", 2, 2, 2, 0, 1);
      if (i == 11) expv("touch11", 2, 2, 2, 0, 0);
      if (i == 12) expv("touch12", 2, 3, 2, 0, 1);
    end
    step(0, 0, 0, 1, 0); expv("play_152", 2, 3, 2, 0, 0);
    step(1, 0, 1, 0, 0); expv("hot_tick1", 1, 3, 2, 0, 1);
    repeat (10) step(1, 0, 1, 0, 0);
    step(1, 0, 1, 0, 0); expv("hot_tick12", 1, 3, 2, 0, 0);
    step(1, 0, 1, 0, 0); expv("hot_tick13", 1, 3, 1, 0, 1);
    // exhaustion, ignored play, feed recovery
    do_reset("reset_async_2");
    repeat (126) step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0); expv("energy_1", 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0); expv("exhausted", 0, 0, 0, 2, 1);
    repeat (2) step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0); expv("exh_play_ignored", 0, 0, 0, 2, 0);
    step(1, 0, 0, 0, 0); expv("exh_tick_floor", 0, 0, 0, 2, 0);
    step(0, 1, 0, 0, 0); expv("exh_feed_awake", 0, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0); expv("feed_64", 1, 0, 0, 0, 1);
    // sleep until energy saturates, then touch wakes
    do_reset("reset_async_3");
    step(0, 0, 0, 0, 1); expv("sleep_enter", 2, 0, 2, 1, 1);
    step(1, 0, 0, 0, 1); expv("sleep_tick1", 2, 0, 1, 1, 1);
    repeat (14) step(1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1); expv("sleep_tick16", 3, 0, 1, 1, 1);
    repeat (14) step(1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1); expv("sleep_tick31", 3, 0, 1, 1, 0);
    step(1, 0, 0, 0, 1); expv("sleep_full_wake", 3, 0, 1, 0, 1);
    step(1, 0, 0, 0, 1); expv("resleep", 3, 0, 1, 1, 1);
    step(0, 0, 1, 0, 1); expv("touch_wake", 3, 0, 1, 0, 1);
    repeat (2) step(0, 0, 1, 0, 1);
    step(0, 0, 1, 0, 1); expv("touch_gain_kept", 3, 1, 1, 1, 1);
    // feed and tick together near the top must saturate
    do_reset("reset_async_4");
    for (int i = 1; i <= 4; i++) step(0, 1, 0, 0, 0);
    expv("feed_sat", 3, 0, 2, 0, 0);
    repeat (4) step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0); expv("energy_250", 3, 0, 1, 0, 0);
    step(1, 1, 0, 0, 0); expv("feed_tick_255", 3, 0, 1, 0, 0);
    repeat (62) step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0); expv("drain_192", 3, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0); expv("drain_191", 2, 0, 0, 0, 1);
    // reset while exhausted with play pending
    do_reset("reset_async_5");
    repeat (127) step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0); expv("exhausted_again", 0, 0, 0, 2, 1);
    step(0, 0, 0, 1, 0);
    #2 reset = 1;
    #1 chk("reset_in_exhausted", 32'(outs()), 32'({2'd2, 2'd0, 2'd2, 2'd0, 1'b0}));
    @(negedge clk);
    play = 0;
    reset = 0;
    step(0, 0, 0, 0, 0); expv("post_reset_idle", 2, 0, 2, 0, 0);
    for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk);
    #2 chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/affect_integrator.md
AFFECT_INTEGRATOR -- requirements
Module: affect_integrator

Interface
REQ-001 Parameter ENERGY_DECAY, default 1: energy lost per tick while AWAKE.
REQ-002 Parameter SLEEP_GAIN, default 4: energy gained per tick while SLEEP.
REQ-003 Parameter FEED_GAIN, default 32: energy added per feed pulse.
REQ-004 Parameter TOUCH_GAIN, default 16: stress added per touch pulse.
REQ-005 Parameter PLAY_GAIN, default 24: pleasure added per play pulse.
REQ-006 Parameter DECAY, default 1: per-tick decay of stress and pleasure.
REQ-007 clk  input  1  single clock; all state changes on its rising edge.
REQ-008 reset  input  1  reset is asynchronous and active-high.
REQ-009 tick  input  1  one-cycle time-base strobe.
REQ-010 feed  input  1  one-cycle event pulse.
REQ-011 touch  input  1  one-cycle event pulse.
REQ-012 play  input  1  one-cycle event pulse.
REQ-013 night  input  1  level; darkness request.
REQ-014 energy  output  2  energy_lvl[7:6].
REQ-015 stress  output  2  stress_lvl[7:6].
REQ-016 pleasure  output  2  pleasure_lvl[7:6].
REQ-017 mood_state  output  2  FSM state: AWAKE=00, SLEEP=01, EXHAUSTED=10.
REQ-018 mood_update  output  1  one-cycle pulse when any 2-bit output field changes.

Function
REQ-019 The block SHALL hold three 8-bit unsigned levels: energy_lvl, stress_lvl and pleasure_lvl.
REQ-020 Each level SHALL update once per cycle from the sum of all active contributions in that cycle, computed at 10-bit signed width and saturated to 0..255.
REQ-021 Simultaneous events and tick SHALL all apply in the same cycle; no event SHALL be dropped except where REQ-027 requires it.
REQ-022 In every state, tick SHALL subtract DECAY from pleasure_lvl, doubled to 2*DECAY while stress_lvl >= 192.
REQ-023 feed SHALL add FEED_GAIN to energy_lvl, touch SHALL add TOUCH_GAIN to stress_lvl, and play SHALL add PLAY_GAIN to pleasure_lvl, in every state except as REQ-027 limits.
REQ-024 In AWAKE, tick SHALL subtract ENERGY_DECAY from energy_lvl and DECAY from stress_lvl.
REQ-025 The AWAKE transitions SHALL be, in priority order:
- next energy_lvl == 0 -> EXHAUSTED;
- else night == 1 -> SLEEP;
- else stay in AWAKE.
REQ-026 In SLEEP, tick SHALL add SLEEP_GAIN to energy_lvl and subtract 2*DECAY from stress_lvl. The SLEEP transitions SHALL be:
- touch -> AWAKE, and the touch gain still applies;
- night == 0 -> AWAKE;
- next energy_lvl == 255 -> AWAKE.
REQ-027 In EXHAUSTED, play SHALL be ignored and tick SHALL add 1 to stress_lvl. The EXHAUSTED transitions SHALL be, in priority order:
- feed -> AWAKE;
- else night == 1 -> SLEEP.
REQ-028 The transition decision SHALL use the same-cycle next level values, so a state and its levels always change on the same edge.
REQ-029 The energy, stress and pleasure outputs SHALL be direct slices of the level registers, with zero added latency after the updating edge.
REQ-030 mood_update SHALL be registered: it SHALL be high for exactly the one cycle following an edge at which any 2-bit output field changed, and low otherwise.
REQ-031 Saturation SHALL hold at the boundaries: a level at 255 with a gain SHALL stay at 255, and a level at 0 with a decay SHALL stay at 0, without wrap.

Reset
REQ-032 Asserting reset SHALL immediately set energy_lvl=128, stress_lvl=0, pleasure_lvl=128, mood_state=AWAKE and mood_update=0, so the outputs read energy=2, stress=0, pleasure=2.
REQ-033 Reset asserted mid-operation SHALL discard all pending events, including events in the cycle where reset is released.
REQ-034 The first update SHALL occur on the first rising edge after reset deasserts.

Structure
REQ-035 The state encoding and the default gain constants SHALL live in the shared package mimosa_pkg.
REQ-036 Saturating add/subtract SHALL be one sub-module, sat_level (8-bit level, signed 10-bit delta in, saturated level out), instantiated three times.
REQ-037 The FSM SHALL reside in affect_integrator.

Verification
REQ-038 Reset release, then 64 ticks with no events -> energy_lvl=64, energy=1, stress=0, pleasure_lvl=64, one mood_update per field change.
REQ-039 From reset, touch on 12 consecutive cycles with no tick -> stress_lvl=192, stress=3; each subsequent tick decrements pleasure_lvl by 2.
REQ-040 energy_lvl=1 in AWAKE, then tick -> energy_lvl=0 and mood_state=EXHAUSTED on the same edge; a later play leaves pleasure_lvl unchanged; a later feed -> energy_lvl=32 and AWAKE.
REQ-041 night=1 from reset, then 32 ticks -> SLEEP entered on the first edge, energy_lvl saturates at 255, then AWAKE; a touch while in SLEEP -> AWAKE with stress_lvl=16.
REQ-042 feed and tick on the same cycle in AWAKE with energy_lvl=250 -> energy_lvl=255, not 249 and not wrapped.
REQ-043 reset asserted while the FSM is in EXHAUSTED, with play pending -> outputs 2/0/2, AWAKE, and mood_update=0 asynchronously.
